// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Multi-cycle multiply/divide sequencer and owner of the HI/LO registers.
// The EX stage starts MULT/MULTU/DIV/DIVU with a one-cycle strobe. The
// operands are latched at the accept edge. After a fixed latency the
// sequencer writes HI/LO in a single update. MTHI/MTLO write HI/LO directly
// on the next edge and do not occupy the unit.
//
// Ports
//   Clk           in   rising-edge clock
//   Reset         in   asynchronous, active-low reset
//   E_md_signal   in   EX holds an md instruction this cycle (start strobe)
//   E_md_control  in   op: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI,
//                      6 MTLO, 7 reserved (treated as NOP)
//   E_A           in   rs operand (multiplicand / dividend / MT* source)
//   E_B           in   rt operand (multiplier / divisor)
//   D_md_use      in   ID holds an instruction that needs the md unit
//   md_busy       out  operation in flight (registered)
//   md_stall      out  stall request to ID (combinational)
//   md_done       out  one-cycle pulse while a fresh HI/LO result is visible
//   res_hi        out  HI register
//   res_lo        out  LO register
// ---------------------------------------------------------------------------
module md_sequencer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        E_md_signal,
  input  logic [2:0]  E_md_control,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_md_use,
  output logic        md_busy,
  output logic        md_stall,
  output logic        md_done,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Counter load values: the result lands on the edge where the counter
  // reads zero, so loading LAT-1 gives exactly LAT busy cycles.
  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [31:0]       a_q,     a_d;
  logic [31:0]       b_q,     b_d;
  logic              sgn_q,   sgn_d;
  logic [31:0]       hi_q,    hi_d;
  logic [31:0]       lo_q,    lo_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  // Arithmetic datapath (driven only by the latched operands)
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [63:0] mul_prod_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] div_q_s;
  logic [31:0] div_r_s;
  logic        mdu_start_s;

  // Two's-complement negate, used for magnitude conversion and sign restore.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // Multiplier: sign-extending for MULT makes the low 64 bits of an
  // unsigned 64x64 product equal to the signed 64-bit product.
  always_comb begin
    a_ext_s    = {{32{sgn_q & a_q[31]}}, a_q};
    b_ext_s    = {{32{sgn_q & b_q[31]}}, b_q};
    mul_prod_s = a_ext_s * b_ext_s;
  end

  // Operand magnitudes for the divider.
  always_comb begin
    a_neg_s = sgn_q & a_q[31];
    b_neg_s = sgn_q & b_q[31];
    if (a_neg_s) begin
      a_mag_s = neg32(a_q);
    end else begin
      a_mag_s = a_q;
    end
    if (b_neg_s) begin
      b_mag_s = neg32(b_q);
    end else begin
      b_mag_s = b_q;
    end
  end

  // Divider: unsigned divide on magnitudes, then restore signs. Quotient
  // truncates toward zero, remainder follows the dividend. The
  // 8000_0000 / -1 case falls out naturally (quotient wraps to 8000_0000).
  always_comb begin
    q_mag_s = 32'd0;
    r_mag_s = 32'd0;
    div_q_s = 32'd0;
    div_r_s = 32'd0;
    if (b_q == 32'd0) begin
      div_q_s = 32'hFFFF_FFFF;
      div_r_s = a_q;
    end else begin
      q_mag_s = a_mag_s / b_mag_s;
      r_mag_s = a_mag_s % b_mag_s;
      if (a_neg_s ^ b_neg_s) begin
        div_q_s = neg32(q_mag_s);
      end else begin
        div_q_s = q_mag_s;
      end
      if (a_neg_s) begin
        div_r_s = neg32(r_mag_s);
      end else begin
        div_r_s = r_mag_s;
      end
    end
  end

  // EX is presenting a multi-cycle op (MT* is a one-cycle write, no stall).
  always_comb begin
    if (E_md_signal) begin
      case (E_md_control)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: mdu_start_s = 1'b1;
        default:                            mdu_start_s = 1'b0;
      endcase
    end else begin
      mdu_start_s = 1'b0;
    end
  end

  // Next-state, counter, operand latch and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (E_md_signal) begin
          case (E_md_control)
            OP_MULT, OP_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = MUL_CNT;
              a_d     = E_A;
              b_d     = E_B;
              sgn_d   = (E_md_control == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_d = ST_DIV;
              cnt_d   = DIV_CNT;
              a_d     = E_A;
              b_d     = E_B;
              sgn_d   = (E_md_control == OP_DIV);
            end
            OP_MTHI: hi_d = E_A;
            OP_MTLO: lo_d = E_A;
            OP_NOP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_ZERO) begin
          hi_d    = mul_prod_s[63:32];
          lo_d    = mul_prod_s[31:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DIV: begin
        if (cnt_q == CNT_ZERO) begin
          hi_d    = div_r_s;
          lo_d    = div_q_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Stall covers the accept cycle too, before busy has risen.
  assign md_stall = D_md_use & (busy_q | mdu_start_s);
  assign md_busy  = busy_q;
  assign md_done  = done_q;
  assign res_hi   = hi_q;
  assign res_lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//
// Directed test of md_sequencer: inputs change and outputs are sampled on
// the falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        E_md_signal = 1'b0;
  logic [2:0]  E_md_control = 3'd0;
  logic [31:0] E_A = 32'd0;
  logic [31:0] E_B = 32'd0;
  logic        D_md_use = 1'b0;
  logic        md_busy;
  logic        md_stall;
  logic        md_done;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  int n_cmp = 0;
  int n_mis = 0;

  // Expected HI/LO contents as tracked by the bench.
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;

  md_sequencer #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .E_md_signal  (E_md_signal),
    .E_md_control (E_md_control),
    .E_A          (E_A),
    .E_B          (E_B),
    .D_md_use     (D_md_use),
    .md_busy      (md_busy),
    .md_stall     (md_stall),
    .md_done      (md_done),
    .res_hi       (res_hi),
    .res_lo       (res_lo)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Present a multi-cycle op for one cycle (called at a falling edge),
  // then scramble the operands so a late re-latch would corrupt the result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    E_md_signal  = 1'b1;
    E_md_control = op;
    E_A          = a;
    E_B          = b;
    #1;
    check_val("stall_accept", md_stall, D_md_use);
    check_val("busy_accept", md_busy, 1'b0);
    @(negedge Clk);
    E_md_signal  = 1'b0;
    E_md_control = 3'd0;
    E_A          = 32'hDEAD_BEEF;
    E_B          = 32'd0;
    check_val("done_low_after_accept", md_done, 1'b0);
  endtask

  // Count busy cycles (bounded), checking held HI/LO and stall each cycle,
  // then check the completion values. Optionally injects a MULT start
  // mid-operation, which must be ignored.
  task automatic wait_done(input string tag, input int lat,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input bit inj);
    int cyc;
    cyc = 0;
    while (md_busy === 1'b1 && cyc < 40) begin
      check_val({tag, "_hold_hi"}, res_hi, mdl_hi);
      check_val({tag, "_hold_lo"}, res_lo, mdl_lo);
      check_val({tag, "_no_done"}, md_done, 1'b0);
      check_val({tag, "_stall"}, md_stall, D_md_use);
      if (inj && cyc == 2) begin
        E_md_signal  = 1'b1;
        E_md_control = OP_MULT;
        E_A          = 32'd5;
        E_B          = 32'd5;
      end
      if (inj && cyc == 3) begin
        E_md_signal  = 1'b0;
        E_md_control = 3'd0;
      end
      @(negedge Clk);
      cyc++;
    end
    check_val({tag, "_latency"}, cyc, lat);
    check_val({tag, "_done"}, md_done, 1'b1);
    check_val({tag, "_hi"}, res_hi, exp_hi);
    check_val({tag, "_lo"}, res_lo, exp_lo);
    mdl_hi = exp_hi;
    mdl_lo = exp_lo;
  endtask

  initial begin
    // Reset state
    D_md_use = 1'b1;
    #1;
    check_val("rst_busy", md_busy, 1'b0);
    check_val("rst_done", md_done, 1'b0);
    check_val("rst_hi", res_hi, 32'd0);
    check_val("rst_lo", res_lo, 32'd0);
    check_val("rst_stall", md_stall, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    // MULT -1*2, then MULTU back-to-back in the completion cycle
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
    @(negedge Clk);
    check_val("done_single_pulse", md_done, 1'b0);

    // Signed divide with no ID user: stall must stay low
    D_md_use = 1'b0;
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7_m2", 10, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    @(negedge Clk);
    D_md_use = 1'b1;

    // DIVU with an ignored mid-flight MULT start
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_done("divu_7_2", 10, 32'h0000_0001, 32'h0000_0003, 1'b1);
    @(negedge Clk);

    // Negative dividend: remainder takes the dividend's sign
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_m7_2", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    @(negedge Clk);

    // Divide by zero, signed and unsigned
    issue(OP_DIV, 32'h0000_1234, 32'd0);
    wait_done("div_by0", 10, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
    @(negedge Clk);
    issue(OP_DIVU, 32'h8000_0001, 32'd0);
    wait_done("divu_by0", 10, 32'h8000_0001, 32'hFFFF_FFFF, 1'b0);
    @(negedge Clk);

    // Signed overflow
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10, 32'h0000_0000, 32'h8000_0000, 1'b0);
    @(negedge Clk);

    // -1 * -1 signed vs unsigned
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult_m1m1", 5, 32'h0000_0000, 32'h0000_0001, 1'b0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 5, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge Clk);

    // MTHI / MTLO: one-cycle write, no stall, no busy, no done
    E_md_signal  = 1'b1;
    E_md_control = OP_MTHI;
    E_A          = 32'h0000_0055;
    #1;
    check_val("mthi_stall", md_stall, 1'b0);
    @(negedge Clk);
    check_val("mthi_hi", res_hi, 32'h0000_0055);
    check_val("mthi_lo", res_lo, 32'h0000_0001);
    check_val("mthi_busy", md_busy, 1'b0);
    check_val("mthi_done", md_done, 1'b0);
    E_md_control = OP_MTLO;
    E_A          = 32'h0000_00AA;
    #1;
    check_val("mtlo_stall", md_stall, 1'b0);
    @(negedge Clk);
    check_val("mtlo_hi", res_hi, 32'h0000_0055);
    check_val("mtlo_lo", res_lo, 32'h0000_00AA);
    check_val("mtlo_busy", md_busy, 1'b0);
    mdl_hi = 32'h0000_0055;
    mdl_lo = 32'h0000_00AA;

    // Reserved op acts as NOP
    E_md_control = OP_RSVD;
    E_A          = 32'h0000_1234;
    #1;
    check_val("rsvd_stall", md_stall, 1'b0);
    @(negedge Clk);
    E_md_signal  = 1'b0;
    E_md_control = 3'd0;
    check_val("rsvd_busy", md_busy, 1'b0);
    check_val("rsvd_hi", res_hi, 32'h0000_0055);
    check_val("rsvd_lo", res_lo, 32'h0000_00AA);

    // Reset in cycle 3 of a DIV aborts it immediately
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (2) @(negedge Clk);
    check_val("pre_rst_busy", md_busy, 1'b1);
    Reset = 1'b0;
    #1;
    check_val("midrst_busy", md_busy, 1'b0);
    check_val("midrst_done", md_done, 1'b0);
    check_val("midrst_hi", res_hi, 32'd0);
    check_val("midrst_lo", res_lo, 32'd0);
    check_val("midrst_stall", md_stall, 1'b0);
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (12) begin
      @(negedge Clk);
      check_val("post_rst_no_done", md_done, 1'b0);
      check_val("post_rst_no_busy", md_busy, 1'b0);
    end
    issue(OP_MULT, 32'd3, 32'd4);
    wait_done("mult_after_rst", 5, 32'h0000_0000, 32'h0000_000C, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
